// File: rtl/rsa_operand_loader_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rsa_operand_loader_if
// Purpose  : Bundles the host write bus, the crypt-core handshake and the
//            status outputs of the RSA operand loader.
// Signals  : wr_valid/wr_addr/wr_data - host word write (addr 3 = command)
//            eoc                      - end of conversion from the crypt core
//            P_o/E_o/M_o              - operand registers feeding the core
//            start                    - one-cycle start pulse to the core
//            busy/done/err            - run status
// Modports : master - host/core side, slave - the loader
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface rsa_operand_loader_if #(
   parameter int WIDTH = 10
);
   logic             wr_valid;
   logic [1:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             eoc;
   logic [WIDTH-1:0] P_o;
   logic [WIDTH-1:0] E_o;
   logic [WIDTH-1:0] M_o;
   logic             start;
   logic             busy;
   logic             done;
   logic [1:0]       err;

   modport master (
      output wr_valid, wr_addr, wr_data, eoc,
      input  P_o, E_o, M_o, start, busy, done, err
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, eoc,
      output P_o, E_o, M_o, start, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/rsa_operand_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rsa_operand_loader
// Purpose  : Input-side front end of the RSA modular-exponentiation datapath.
//            Captures plaintext/exponent/modulus words from the host,
//            validates them on a go command, issues a one-cycle start to the
//            crypt core, watches for end-of-conversion with a timeout and
//            reports busy, sticky done and sticky first-error status.
// Ports    : clk  - rising-edge clock
//            rstb - synchronous active-low reset
//            en   - clock enable, every register holds while low
//            bus  - rsa_operand_loader_if.slave (write bus, eoc, operands,
//                   start, busy, done, err)
// Params   : WIDTH   - operand/data width in bits (>= 2)
//            TIMEOUT - RUN cycles allowed before abort
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rsa_operand_loader #(
   parameter int WIDTH   = 10,
   parameter int TIMEOUT = 1024
) (
   input  wire logic           clk,
   input  wire logic           rstb,
   input  wire logic           en,
   rsa_operand_loader_if.slave bus
);

   localparam int             c_CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

   localparam logic [1:0] c_ERR_NONE    = 2'b00;
   localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] c_ERR_OPERAND = 2'b10;
   localparam logic [1:0] c_ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_e;
   logic [WIDTH-1:0] r_m;
   logic [2:0]       r_loaded;   // {M, E, P}
   logic             r_start;
   logic             r_busy;
   logic             r_done;
   logic [1:0]       r_err;
   logic [c_CW-1:0]  r_cnt;

   // Write decode. One write per cycle, so an operand write, a go and a
   // clear can never coincide.
   logic w_wr_operand;
   logic w_wr_cmd;
   logic w_go;
   logic w_clear;
   logic w_all_loaded;
   logic w_bad_operand;
   logic w_timeout;

   assign w_wr_operand  = bus.wr_valid && (bus.wr_addr != 2'd3);
   assign w_wr_cmd      = bus.wr_valid && (bus.wr_addr == 2'd3);
   assign w_clear       = w_wr_cmd && bus.wr_data[1];
   // A clear in the same word masks go.
   assign w_go          = w_wr_cmd && bus.wr_data[0] && !bus.wr_data[1];
   assign w_all_loaded  = &r_loaded;
   assign w_bad_operand = (r_m == '0) || (r_p >= r_m);
   // eoc has priority over the timeout in the same cycle.
   assign w_timeout     = (r_state == S_RUN) && !bus.eoc && (r_cnt == c_CNT_LAST);

   // Error raised by this cycle's activity; committed only if err is still
   // clear, which gives first-error-wins behaviour.
   logic [1:0] w_err_code;

   always_comb begin
      w_err_code = c_ERR_NONE;
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               if (!w_all_loaded) begin
                  w_err_code = c_ERR_ILLEGAL;
               end else if (w_bad_operand) begin
                  w_err_code = c_ERR_OPERAND;
               end
            end
         end
         S_START: begin
            if (w_wr_operand || w_go) begin
               w_err_code = c_ERR_ILLEGAL;
            end
         end
         S_RUN: begin
            if (w_timeout) begin
               w_err_code = c_ERR_TIMEOUT;
            end else if (w_wr_operand || w_go) begin
               w_err_code = c_ERR_ILLEGAL;
            end
         end
         default: w_err_code = c_ERR_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_state  <= S_IDLE;
         r_p      <= '0;
         r_e      <= '0;
         r_m      <= '0;
         r_loaded <= 3'b000;
         r_start  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= c_ERR_NONE;
         r_cnt    <= '0;
      end else if (en) begin
         case (r_state)
            S_IDLE: begin
               if (w_wr_operand) begin
                  case (bus.wr_addr)
                     2'd0: begin
                        r_p         <= bus.wr_data;
                        r_loaded[0] <= 1'b1;
                     end
                     2'd1: begin
                        r_e         <= bus.wr_data;
                        r_loaded[1] <= 1'b1;
                     end
                     default: begin
                        r_m         <= bus.wr_data;
                        r_loaded[2] <= 1'b1;
                     end
                  endcase
               end else if (w_go && w_all_loaded && !w_bad_operand) begin
                  r_state <= S_START;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end

            // Start is held for exactly one enabled cycle; eoc is not
            // looked at here because the core cannot have finished yet.
            S_START: begin
               r_start <= 1'b0;
               r_state <= S_RUN;
               r_cnt   <= '0;
            end

            S_RUN: begin
               if (bus.eoc) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + c_CW'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_start <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase

         // Clear works in any state without touching the run or operands.
         if (w_clear) begin
            r_done   <= 1'b0;
            r_err    <= c_ERR_NONE;
            r_loaded <= 3'b000;
         end else if ((r_err == c_ERR_NONE) && (w_err_code != c_ERR_NONE)) begin
            r_err <= w_err_code;
         end
      end
   end

   assign bus.P_o   = r_p;
   assign bus.E_o   = r_e;
   assign bus.M_o   = r_m;
   assign bus.start = r_start;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rsa_operand_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_rsa_operand_loader
// Purpose  : Self-checking bench for rsa_operand_loader (WIDTH=10, TIMEOUT=8).
//            Each accepted go pushes the expected end-of-run status to a
//            scoreboard queue; a monitor pops and compares it when busy falls.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rsa_operand_loader;

   localparam int c_WIDTH   = 10;
   localparam int c_TIMEOUT = 8;

   typedef struct {
      logic [c_WIDTH-1:0] p;
      logic [c_WIDTH-1:0] e;
      logic [c_WIDTH-1:0] m;
      logic               done;
      logic [1:0]         err;
   } exp_t;

   logic clk;
   logic rstb;
   logic en;
   int   n_checks;
   int   n_errors;
   logic r_prev_busy;
   exp_t sb[$];

   rsa_operand_loader_if #(.WIDTH(c_WIDTH)) bus ();

   rsa_operand_loader #(
      .WIDTH   (c_WIDTH),
      .TIMEOUT (c_TIMEOUT)
   ) u_dut (
      .clk  (clk),
      .rstb (rstb),
      .en   (en),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] addr, input logic [c_WIDTH-1:0] data);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = addr;
      bus.wr_data  = data;
      step();
      bus.wr_valid = 1'b0;
   endtask

   task automatic load_ops(input logic [c_WIDTH-1:0] p, input logic [c_WIDTH-1:0] e,
                           input logic [c_WIDTH-1:0] m);
      wr(2'd0, p);
      wr(2'd1, e);
      wr(2'd2, m);
   endtask

   task automatic sb_push(input logic [c_WIDTH-1:0] p, input logic [c_WIDTH-1:0] e,
                          input logic [c_WIDTH-1:0] m, input logic d, input logic [1:0] er);
      exp_t x;
      x.p = p; x.e = e; x.m = m; x.done = d; x.err = er;
      sb.push_back(x);
   endtask

   // End-of-run monitor: every falling edge of busy must match a queued run.
   initial r_prev_busy = 1'b0;
   always @(negedge clk) begin
      if (r_prev_busy && !bus.busy) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_end", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("sb_P",    32'(bus.P_o),  32'(x.p));
            chk("sb_E",    32'(bus.E_o),  32'(x.e));
            chk("sb_M",    32'(bus.M_o),  32'(x.m));
            chk("sb_done", 32'(bus.done), 32'(x.done));
            chk("sb_err",  32'(bus.err),  32'(x.err));
         end
      end
      r_prev_busy = bus.busy;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rstb         = 1'b0;
      en           = 1'b1;
      bus.wr_valid = 1'b0;
      bus.wr_addr  = 2'd0;
      bus.wr_data  = '0;
      bus.eoc      = 1'b0;
      step();
      step();
      chk("rst_P",     32'(bus.P_o),   32'd0);
      chk("rst_busy",  32'(bus.busy),  32'd0);
      chk("rst_start", 32'(bus.start), 32'd0);
      chk("rst_done",  32'(bus.done),  32'd0);
      chk("rst_err",   32'(bus.err),   32'd0);
      rstb = 1'b1;
      step();

      // 1: normal run
      wr(2'd0, 10'd5);
      chk("t1_P_load", 32'(bus.P_o), 32'd5);
      wr(2'd1, 10'd3);
      wr(2'd2, 10'd33);
      chk("t1_E_load", 32'(bus.E_o), 32'd3);
      chk("t1_M_load", 32'(bus.M_o), 32'd33);
      sb_push(10'd5, 10'd3, 10'd33, 1'b1, 2'b00);
      wr(2'd3, 10'd1);
      chk("t1_start", 32'(bus.start), 32'd1);
      chk("t1_busy",  32'(bus.busy),  32'd1);
      step();
      chk("t1_start_off", 32'(bus.start), 32'd0);
      chk("t1_busy_run",  32'(bus.busy),  32'd1);
      repeat (4) step();
      bus.eoc = 1'b1;
      step();
      bus.eoc = 1'b0;
      chk("t1_busy_end", 32'(bus.busy), 32'd0);
      chk("t1_done",     32'(bus.done), 32'd1);

      // 2: invalid operand, then clear and a good run
      wr(2'd0, 10'd40);
      wr(2'd3, 10'd1);
      chk("t2_err_operand", 32'(bus.err),   32'd2);
      chk("t2_no_start",    32'(bus.start), 32'd0);
      step();
      chk("t2_no_start2",   32'(bus.start), 32'd0);
      chk("t2_idle",        32'(bus.busy),  32'd0);
      chk("t2_done_kept",   32'(bus.done),  32'd1);
      wr(2'd3, 10'd2);
      chk("t2_clr_err",  32'(bus.err),  32'd0);
      chk("t2_clr_done", 32'(bus.done), 32'd0);
      chk("t2_P_intact", 32'(bus.P_o),  32'd40);
      load_ops(10'd7, 10'd3, 10'd33);
      sb_push(10'd7, 10'd3, 10'd33, 1'b1, 2'b00);
      wr(2'd3, 10'd1);
      chk("t2_start", 32'(bus.start), 32'd1);
      repeat (3) step();
      bus.eoc = 1'b1;
      step();
      bus.eoc = 1'b0;
      chk("t2_done", 32'(bus.done), 32'd1);

      // 3: missing operand, then illegal write during a run
      wr(2'd3, 10'd2);
      wr(2'd0, 10'd7);
      wr(2'd1, 10'd3);
      wr(2'd3, 10'd1);
      chk("t3_err_unloaded", 32'(bus.err),  32'd1);
      chk("t3_idle",         32'(bus.busy), 32'd0);
      wr(2'd3, 10'd2);
      load_ops(10'd7, 10'd3, 10'd33);
      sb_push(10'd7, 10'd3, 10'd33, 1'b1, 2'b01);
      wr(2'd3, 10'd1);
      step();
      wr(2'd2, 10'd99);
      chk("t3_M_held",     32'(bus.M_o), 32'd33);
      chk("t3_err_access", 32'(bus.err), 32'd1);
      bus.eoc = 1'b1;
      step();
      bus.eoc = 1'b0;
      chk("t3_done", 32'(bus.done), 32'd1);

      // 4a: timeout
      wr(2'd3, 10'd2);
      load_ops(10'd7, 10'd3, 10'd33);
      sb_push(10'd7, 10'd3, 10'd33, 1'b0, 2'b11);
      wr(2'd3, 10'd1);
      step();
      repeat (c_TIMEOUT - 1) step();
      chk("t4_busy_before_to", 32'(bus.busy), 32'd1);
      step();
      chk("t4_busy_to", 32'(bus.busy), 32'd0);
      chk("t4_err_to",  32'(bus.err),  32'd3);
      chk("t4_done_to", 32'(bus.done), 32'd0);

      // 4b: eoc on the last counter cycle wins over timeout
      wr(2'd3, 10'd2);
      load_ops(10'd7, 10'd3, 10'd33);
      sb_push(10'd7, 10'd3, 10'd33, 1'b1, 2'b00);
      wr(2'd3, 10'd1);
      step();
      repeat (c_TIMEOUT - 1) step();
      bus.eoc = 1'b1;
      step();
      bus.eoc = 1'b0;
      chk("t4_done_last", 32'(bus.done), 32'd1);
      chk("t4_err_last",  32'(bus.err),  32'd0);

      // 5: clock enable freezes start width and the counter
      wr(2'd3, 10'd2);
      load_ops(10'd7, 10'd3, 10'd33);
      sb_push(10'd7, 10'd3, 10'd33, 1'b1, 2'b00);
      wr(2'd3, 10'd1);
      chk("t5_start", 32'(bus.start), 32'd1);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_start_hold", 32'(bus.start), 32'd1);
      end
      en = 1'b1;
      step();
      chk("t5_start_off", 32'(bus.start), 32'd0);
      chk("t5_busy",      32'(bus.busy),  32'd1);
      repeat (2) step();
      en      = 1'b0;
      bus.eoc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_eoc_ignored", 32'(bus.busy), 32'd1);
      end
      bus.eoc = 1'b0;
      en      = 1'b1;
      repeat (5) step();
      chk("t5_cnt_frozen", 32'(bus.busy), 32'd1);
      bus.eoc = 1'b1;
      step();
      bus.eoc = 1'b0;
      chk("t5_done", 32'(bus.done), 32'd1);

      // 6: reset mid-run
      sb_push(10'd0, 10'd0, 10'd0, 1'b0, 2'b00);
      wr(2'd3, 10'd1);
      step();
      rstb = 1'b0;
      step();
      rstb = 1'b1;
      chk("t6_P",     32'(bus.P_o),   32'd0);
      chk("t6_M",     32'(bus.M_o),   32'd0);
      chk("t6_busy",  32'(bus.busy),  32'd0);
      chk("t6_start", 32'(bus.start), 32'd0);
      chk("t6_done",  32'(bus.done),  32'd0);
      wr(2'd3, 10'd1);
      chk("t6_err_unloaded", 32'(bus.err),  32'd1);
      chk("t6_idle",         32'(bus.busy), 32'd0);

      repeat (2) step();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
